// File: rtl/cmd_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cmd_frame_tx
//  Description : Command frame transmitter. Accepts one {code, data} command
//                per handshake and serialises the 8-byte frame
//                {PREFIX, code, data, SUFFIX} LSB byte first into a
//                txfifo-style write port, honouring the FIFO full flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_tx #(
  parameter logic [7:0] PREFIX = 8'hAA,
  parameter logic [7:0] SUFFIX = 8'h55,
  parameter int         CNT_W  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_code,
  input  logic [31:0]      cmd_data,
  output logic [7:0]       txfifo_data,
  output logic             txfifo_wr,
  input  logic             txfifo_full,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0]       c_LAST_IDX = 3'd7;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [63:0]      r_shift;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             w_load;
  logic             w_accept;
  logic             w_last;

  // Next-state and strobe decode; the handshake is only possible in IDLE,
  // so cmd_ready never appears combinationally on an output.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_load       = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (!txfifo_full) begin
          w_accept = 1'b1;
          if (r_idx == c_LAST_IDX) begin
            w_last       = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame shift register and byte index: load at handshake, shift right one
  // byte per accepted write so the LSB byte is always the one on the wire.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift <= 64'd0;
      r_idx   <= 3'd0;
    end else if (w_load) begin
      r_shift <= {PREFIX, cmd_code, cmd_data, SUFFIX};
      r_idx   <= 3'd0;
    end else if (w_accept) begin
      r_shift <= {8'h00, r_shift[63:8]};
      r_idx   <= r_idx + 3'd1;
    end
  end

  // Completed-frame counter; wraps silently.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_cnt <= {CNT_W{1'b0}};
    end else if (w_last) begin
      r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state == SEND);
  assign txfifo_wr   = (r_state == SEND);
  assign txfifo_data = r_shift[7:0];
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
